// File: rtl/fb_reader_pkg.sv
// fb_reader_pkg: constants, the pixel-buffer entry type and the
// framebuffer address helper, shared by the framebuffer reader and its FIFO.
package fb_reader_pkg;

  // RGB 8:8:8 pixel width on the streaming side.
  localparam int PIX_W = 24;

  // One pixel occupies one 32-bit framebuffer word.
  localparam logic [31:0] BYTES_PER_PIX = 32'd4;

  // One pixel-buffer entry: start-of-frame flag plus the colour bits.
  typedef struct packed {
    logic             sof;
    logic [PIX_W-1:0] rgb;
  } fifo_entry_t;

  // Byte address of pixel (x, y) in a raster-ordered framebuffer.
  // The arithmetic is done at 32 bits so large panels cannot truncate.
  function automatic logic [31:0] pix_addr(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic [31:0] hdisp);
    return (x + y * hdisp) * BYTES_PER_PIX;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone classic bus bundle carrying its own clock and reset.
//   clk, rst   : bus clock and synchronous active-high reset
//   cyc, stb   : cycle / strobe from the initiator
//   we, sel    : write enable and byte selects
//   adr        : byte address
//   dat_sm     : read data, slave to master
//   ack        : transfer acknowledge from the slave
//   cti, bte   : cycle type / burst type (classic cycles only)
interface wshb_if (input logic clk, input logic rst);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_sm;
  logic        ack;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    input  clk, rst, dat_sm, ack,
    output cyc, stb, we, sel, adr, cti, bte
  );

  modport slave (
    input  clk, rst, cyc, stb, we, sel, adr, cti, bte,
    output dat_sm, ack
  );

endinterface

// File: rtl/fb_fifo.sv
// fb_fifo: single-clock synchronous FIFO with registered occupancy.
//   clk, rst : clock and synchronous active-high reset (empties the FIFO)
//   push/din : write request and data
//   pop      : read request; dout shows the head entry whenever not empty
//   full, empty, count : occupancy status
// A push is accepted when full only if a pop happens in the same cycle,
// so push+pop always leaves the occupancy unchanged.
module fb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign full      = (count_r == DEPTH_CNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  // Storage array: written at the tail, never reset (occupancy gates reads).
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fb_reader.sv
// fb_reader: reads a raster framebuffer over Wishbone classic, one word at a
// time, and streams the pixels out through a valid/ready interface.
//   wshb_ifm  : Wishbone master (carries clk and synchronous active-high rst)
//   pix_ready : downstream accepts the current pixel
//   pix_valid : pix_data/pix_sof hold a valid pixel (FIFO not empty)
//   pix_data  : RGB 8:8:8 pixel, zero when no pixel is available
//   pix_sof   : current pixel is (0,0) of a frame
module fb_reader
  import fb_reader_pkg::*;
#(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int FIFO_DEPTH = 256
) (
  wshb_if.master           wshb_ifm,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_sof
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST    = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(VDISP - 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(FIFO_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } rd_state_t;

  rd_state_t   state_r;
  rd_state_t   state_s;
  logic [XW-1:0] x_cnt_r;
  logic [YW-1:0] y_cnt_r;
  logic        stb_s;
  logic        xfer_s;
  logic        pop_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  fifo_entry_t push_entry_s;
  fifo_entry_t head_s;
  logic [7:0]  unused_dat_hi_s;

  // The read word's top byte carries no colour information.
  assign unused_dat_hi_s = wshb_ifm.dat_sm[31:24];

  // stb comes straight from the state register; ack only counts under stb.
  assign stb_s  = (state_r == ST_REQ);
  assign xfer_s = stb_s & wshb_ifm.ack;
  assign pop_s  = pix_ready & ~fifo_empty_s;

  assign wshb_ifm.cyc = stb_s;
  assign wshb_ifm.stb = stb_s;
  assign wshb_ifm.we  = 1'b0;
  assign wshb_ifm.sel = 4'b1111;
  assign wshb_ifm.cti = 3'b000;
  assign wshb_ifm.bte = 2'b00;
  // Counters only move on ack, so the address holds for the whole access.
  assign wshb_ifm.adr = pix_addr(32'(x_cnt_r), 32'(y_cnt_r), 32'(HDISP));

  assign push_entry_s.sof = (x_cnt_r == '0) && (y_cnt_r == '0);
  assign push_entry_s.rgb = wshb_ifm.dat_sm[PIX_W-1:0];

  assign pix_valid = ~fifo_empty_s;
  assign pix_data  = fifo_empty_s ? '0 : head_s.rgb;
  assign pix_sof   = ~fifo_empty_s & head_s.sof;

  // Read-request state register.
  always_ff @(posedge wshb_ifm.clk) begin
    if (wshb_ifm.rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. After an ack the strobe stays up for a back-to-back
  // read unless that push is about to fill the FIFO; from idle a new read
  // starts as soon as there is room.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_full_s) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (wshb_ifm.ack) begin
          if ((fifo_count_s == LAST_SLOT) && !pop_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_REQ;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Raster position: x fastest, both wrapping at the frame edges.
  always_ff @(posedge wshb_ifm.clk) begin
    if (wshb_ifm.rst) begin
      x_cnt_r <= '0;
      y_cnt_r <= '0;
    end else if (xfer_s) begin
      if (x_cnt_r == X_LAST) begin
        x_cnt_r <= '0;
        if (y_cnt_r == Y_LAST) begin
          y_cnt_r <= '0;
        end else begin
          y_cnt_r <= y_cnt_r + YW'(1);
        end
      end else begin
        x_cnt_r <= x_cnt_r + XW'(1);
      end
    end
  end

  fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (wshb_ifm.clk),
    .rst   (wshb_ifm.rst),
    .push  (xfer_s),
    .din   (push_entry_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

endmodule

// File: tb/tb_fb_reader.sv
// tb_fb_reader: directed bench for fb_reader on an 8x4 frame with a 4-entry
// pixel buffer. A behavioural Wishbone slave returns {0xEE, adr[23:0]} after
// a programmable number of wait states; a sink checks every accepted pixel
// against the raster model (data = byte address, sof on pixel 0 of a frame).
module tb_fb_reader;

  localparam int HD          = 8;
  localparam int VD          = 4;
  localparam int DEP         = 4;
  localparam int FRAME_PIX   = HD * VD;
  localparam int FRAME_BYTES = FRAME_PIX * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ready = 1'b0;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_sof;

  int total = 0;
  int bad   = 0;

  // slave controls / statistics
  int          waits      = 0;
  int          acks       = 0;
  int          acks_rst   = 0;
  int          wcnt       = 0;
  int          stray_req  = 0;
  int          stray_done = 0;
  logic [31:0] exp_adr    = 32'd0;

  // sink controls / statistics
  int rdy_mode   = 1;   // 0: never ready, 1: always ready, other: random
  int pulse_req  = 0;
  int pulse_done = 0;
  int pix_idx    = 0;

  wshb_if wb (.clk(clk), .rst(rst));

  fb_reader #(
    .HDISP      (HD),
    .VDISP      (VD),
    .FIFO_DEPTH (DEP)
  ) dut (
    .wshb_ifm  (wb.master),
    .pix_ready (pix_ready),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_stb(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (wb.stb === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Wishbone slave: drives ack/dat_sm on the falling edge.
  always @(negedge clk) begin
    if (wb.ack === 1'b1) begin
      wb.ack = 1'b0;
      wcnt   = 0;
    end
    if (rst) begin
      exp_adr   = 32'd0;
      acks_rst  = 0;
      wcnt      = 0;
      wb.ack    = 1'b0;
      wb.dat_sm = 32'd0;
    end else if (wb.stb === 1'b1) begin
      if (wcnt >= waits) begin
        check("slave_adr", wb.adr, exp_adr);
        wb.ack    = 1'b1;
        wb.dat_sm = {8'hEE, wb.adr[23:0]};
        acks++;
        acks_rst++;
        exp_adr = (exp_adr + 32'd4) % 32'(FRAME_BYTES);
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
      if (stray_req != stray_done) begin
        wb.ack     = 1'b1;
        wb.dat_sm  = 32'h00BADBAD;
        stray_done = stray_req;
      end
    end
  end

  // Pixel sink: chooses pix_ready and checks each pixel that will be taken.
  always @(negedge clk) begin
    logic [31:0] exp_data;
    logic [31:0] exp_sof;
    case (rdy_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
    if (pulse_req != pulse_done) begin
      pix_ready  = 1'b1;
      pulse_done = pulse_req;
    end
    if (rst) begin
      pix_idx = 0;
    end else if (pix_valid && pix_ready) begin
      exp_data = 32'((pix_idx % FRAME_PIX) * 4);
      exp_sof  = 32'((pix_idx % FRAME_PIX) == 0);
      check("sink_data", {8'h00, pix_data}, exp_data);
      check("sink_sof", 32'(pix_sof), exp_sof);
      pix_idx++;
    end
  end

  initial begin
    int          a0;
    logic [31:0] adr0;
    bit          seen;

    // reset state
    rst      = 1'b1;
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    check("rst_stb",   32'(wb.stb),    32'd0);
    check("rst_cyc",   32'(wb.cyc),    32'd0);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_data",  32'(pix_data),  32'd0);
    check("rst_sof",   32'(pix_sof),   32'd0);
    check("rst_adr",   wb.adr,         32'd0);
    check("rst_we",    32'(wb.we),     32'd0);
    check("rst_sel",   32'(wb.sel),    32'hF);
    check("rst_cti",   32'(wb.cti),    32'd0);
    check("rst_bte",   32'(wb.bte),    32'd0);

    // zero-wait streaming: back-to-back reads, pixels flow through
    rst = 1'b0;
    wait_stb(20, seen);
    check("a_stb_seen", 32'(seen), 32'd1);
    check("a_first_adr",   wb.adr,          32'd0);
    check("a_first_valid", 32'(pix_valid),  32'd0);
    @(negedge clk);
    check("a_valid_after_ack", 32'(pix_valid), 32'd1);
    check("a_first_sof",       32'(pix_sof),   32'd1);
    check("a_first_data",      32'(pix_data),  32'd0);
    check("a_second_adr",      wb.adr,         32'd4);
    repeat (40) @(negedge clk);
    check("a_adr_wrapped", wb.adr,       32'd36);
    check("a_stb_held",    32'(wb.stb),  32'd1);

    // sink stalled: exactly DEP reads, then the strobe stays low
    rst      = 1'b1;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    check("b_rst_stb",   32'(wb.stb),    32'd0);
    check("b_rst_valid", 32'(pix_valid), 32'd0);
    a0  = acks;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("b_acks",  32'(acks - a0), 32'd4);
    check("b_stb",   32'(wb.stb),    32'd0);
    check("b_cyc",   32'(wb.cyc),    32'd0);
    check("b_valid", 32'(pix_valid), 32'd1);
    check("b_head",  32'(pix_data),  32'd0);
    check("b_sof",   32'(pix_sof),   32'd1);

    // stray ack while idle must change nothing
    stray_req = 1;
    repeat (4) @(negedge clk);
    check("stray_stb",  32'(wb.stb),    32'd0);
    check("stray_acks", 32'(acks - a0), 32'd4);
    check("stray_head", 32'(pix_data),  32'd0);
    check("stray_adr",  wb.adr,         32'd16);

    // one ready pulse frees one slot: exactly one new read
    a0        = acks;
    pulse_req = 1;
    repeat (10) @(negedge clk);
    check("pulse_acks", 32'(acks - a0), 32'd1);
    check("pulse_stb",  32'(wb.stb),    32'd0);
    check("pulse_head", 32'(pix_data),  32'd4);
    check("pulse_sof",  32'(pix_sof),   32'd0);

    // five wait states: request held stable for six cycles, one push
    waits    = 5;
    rdy_mode = 1;
    wait_stb(20, seen);
    check("c_stb_seen", 32'(seen), 32'd1);
    adr0 = wb.adr;
    a0   = acks;
    check("c_adr0", adr0, 32'd20);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      check("c_stb_hold", 32'(wb.stb), 32'd1);
      check("c_cyc_hold", 32'(wb.cyc), 32'd1);
      check("c_adr_hold", wb.adr,      adr0);
    end
    @(negedge clk);
    check("c_one_ack",  32'(acks - a0), 32'd1);
    check("c_next_adr", wb.adr,         adr0 + 32'd4);
    check("c_next_stb", 32'(wb.stb),    32'd1);

    // reset mid-access with three pixels buffered
    rdy_mode = 0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    a0  = acks;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (acks - a0 >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    check("d_three_acks", 32'(seen), 32'd1);
    @(negedge clk);
    check("d_pre_stb",   32'(wb.stb),    32'd1);
    check("d_pre_valid", 32'(pix_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("d_rst_stb",   32'(wb.stb),    32'd0);
    check("d_rst_cyc",   32'(wb.cyc),    32'd0);
    check("d_rst_valid", 32'(pix_valid), 32'd0);
    check("d_rst_data",  32'(pix_data),  32'd0);
    check("d_rst_sof",   32'(pix_sof),   32'd0);
    rst      = 1'b0;
    waits    = 0;
    rdy_mode = 2;
    wait_stb(20, seen);
    check("d_stb_seen",  32'(seen), 32'd1);
    check("d_first_adr", wb.adr,    32'd0);

    // random backpressure, then stall until full and check occupancy
    repeat (80) @(negedge clk);
    rdy_mode = 0;
    repeat (20) @(negedge clk);
    check("e_full_stb",  32'(wb.stb),             32'd0);
    check("e_occupancy", 32'(acks_rst - pix_idx), 32'(DEP));
    check("e_head_data", 32'(pix_data),           32'((pix_idx % FRAME_PIX) * 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_reader.md
FB_READER -- requirements
Module: fb_reader

Interface
REQ-001 The block SHALL have parameter HDISP, default 800, pixels per line.
REQ-002 The block SHALL have parameter VDISP, default 480, lines per frame.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 256, pixel buffer entries, power of two, at least 4.
REQ-004 The block SHALL take its clock as wshb_ifm.clk, input, 1 bit; one clock, all logic on its rising edge.
REQ-005 The block SHALL take its reset as wshb_ifm.rst, input, 1 bit, synchronous, active-high.
REQ-006 The block SHALL expose port wshb_ifm, wshb_if.master modport, Wishbone classic read initiator toward the framebuffer.
REQ-007 The block SHALL have port pix_ready, input, 1 bit, downstream accepts the pixel.
REQ-008 The block SHALL have port pix_valid, output, 1 bit, pix_data holds a valid pixel.
REQ-009 The block SHALL have port pix_data, output, 24 bits, RGB 8:8:8 pixel.
REQ-010 The block SHALL have port pix_sof, output, 1 bit, pixel is (x=0, y=0) of a frame.

Function
REQ-011 The block SHALL drive we=0, sel=4'b1111, cti=0, bte=0 and cyc=stb at all times.
REQ-012 The block SHALL drive adr = (x_cnt + y_cnt*HDISP)*4, byte address, raster order, x fastest.
REQ-013 The block SHALL raise stb only when the FIFO is not full; once raised, stb and adr SHALL hold until the cycle ack=1.
REQ-014 The block SHALL allow one outstanding access only; it SHALL NOT pipeline addresses.
REQ-015 On a cycle with stb=1 and ack=1, the block SHALL push {sof, dat_sm[23:0]} into the FIFO, sof=1 iff x_cnt=0 and y_cnt=0; dat_sm[31:24] SHALL be ignored.
REQ-016 On the same ack cycle, x_cnt SHALL increment; at HDISP-1 it SHALL wrap to 0 and y_cnt SHALL increment, wrapping from VDISP-1 to 0.
REQ-017 The block SHALL ignore ack when stb=0; no push, no counter change.
REQ-018 stb MAY be re-asserted in the cycle after ack (back-to-back reads) if the FIFO is still not full.
REQ-019 pix_valid SHALL equal FIFO not-empty; pix_data and pix_sof SHALL present the FIFO head.
REQ-020 A pixel pushed on cycle N SHALL be visible at the FIFO output no earlier than cycle N+1.
REQ-021 The FIFO SHALL pop on pix_valid and pix_ready; pix_data SHALL hold while pix_valid=1 and pix_ready=0.
REQ-022 A simultaneous push and pop SHALL leave the occupancy unchanged, including when full or when holding one entry.
REQ-023 The FIFO SHALL never overflow; the block SHALL never push while full, which the stb rule guarantees since only ack pushes.
REQ-024 Pop with pix_ready=1 while empty SHALL have no effect.

Reset
REQ-025 During reset: stb=0, cyc=0, x_cnt=0, y_cnt=0, FIFO empty, pix_valid=0; pix_data and pix_sof SHALL be 0.
REQ-026 A reset asserted mid-access SHALL drop stb and cyc on the next edge, abandon the access, discard FIFO contents, and restart at address 0.

Structure
REQ-027 A shared package SHALL hold the pixel width (24), the byte-per-pixel constant (4) and the FIFO entry typedef {sof, rgb[23:0]}.
REQ-028 The FIFO SHALL be a separate sub-module fb_fifo (synchronous, single clock, parameterised depth and width, full, empty and count outputs).
REQ-029 x_cnt and y_cnt SHALL be sized $clog2(HDISP) and $clog2(VDISP); the address product SHALL be computed at 32 bits.

Verification
REQ-030 Zero-wait slave, ack in the cycle after stb, pix_ready=1 -> adr sequence 0,4,8,...; first pix_valid 1 cycle after the first ack with pix_sof=1.
REQ-031 HDISP=8, VDISP=4, memory word = address -> after 32 pixels adr returns to 0; pix_sof=1 on pixels 0 and 32 only; pixel 8 data = 0x000020.
REQ-032 pix_ready=0 throughout, FIFO_DEPTH=4 -> exactly 4 acks, then stb=0 indefinitely; one pix_ready pulse -> one new read issued.
REQ-033 Slave inserts 5 wait states -> stb, adr and cyc stable for 6 cycles; exactly one push; stray ack with stb=0 -> no push.
REQ-034 Reset asserted while stb=1 and FIFO holding 3 pixels -> next cycle stb=0, pix_valid=0; after release the first adr=0.
REQ-035 Random pix_ready, FIFO full, push and pop in the same cycle -> count constant, pixel order and data preserved against the memory model.
